clockworks: RTL and testbench

- Clock gearbox and reset conditioner between the board oscillator/button and the SoC core.
- Divides the board clock CLK by a power of two to produce the slow core clock clk.
- Turns the raw board RESET into a clean, stretched, active-low core reset resetn.
- resetn changes only at safe points relative to clk, so the core (CPU, memory) can use it as a synchronous reset in the clk domain.

---
 rtl/clockworks.sv | 114 +++++++++++
 tb/tb_clockworks.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clockworks.sv
// -----------------------------------------------------------------------------
// clockworks - clock gearbox and reset conditioner
//
// Sits between the board oscillator/reset button and the SoC core.
//   * Divides the board clock CLK by 2^(SLOW+1) to make the core clock clk
//     (SLOW = 0 bypasses the divider and passes CLK straight through).
//   * Synchronises the raw active-low board RESET, stretches it and produces
//     the active-low core reset resetn. resetn changes only on the CLK cycle
//     where clk falls, so the core sees it as a clean synchronous reset.
//
// Parameters
//   SLOW        divider exponent, clk period = 2^(SLOW+1) CLK cycles
//   RESET_HOLD  slow ticks resetn stays low after RESET is released (>= 1)
//
// Ports
//   CLK     in   board clock, the only clock of this block
//   RESET   in   board reset, active-low, asynchronous to nothing in particular
//   clk     out  divided core clock
//   resetn  out  core reset, active-low, registered in the CLK domain
//
// State carries power-up values through declaration initialisers; there is no
// reset of this block itself (it is the thing that generates resets).
// -----------------------------------------------------------------------------
module clockworks #(
    parameter int SLOW       = 19,
    parameter int RESET_HOLD = 4
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

    localparam int HW = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    // One-cycle strobe marking the CLK edge on which clk falls.
    logic tick;

    // -------------------------------------------------------------------------
    // Divider. Free running, never touched by RESET so clk keeps running while
    // the core is held in reset.
    // -------------------------------------------------------------------------
    generate
        if (SLOW == 0) begin : g_bypass
            assign clk  = CLK;
            assign tick = 1'b1;
        end else begin : g_div
            localparam logic [SLOW:0] DIV_ONE = (SLOW + 1)'(1);
            logic [SLOW:0] div_reg = '0;

            always_ff @(posedge CLK) begin
                div_reg <= div_reg + DIV_ONE;
            end

            // Straight from a flop output: no glitches on the core clock.
            assign clk  = div_reg[SLOW];
            // div all-ones now means the next edge wraps to 0, i.e. clk falls.
            assign tick = &div_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // RESET synchroniser (two flops) plus a priming shift register that marks
    // when the synchroniser holds real samples of RESET instead of its
    // power-up zeros.
    // -------------------------------------------------------------------------
    logic [1:0] sync_reg  = 2'b00;
    logic [1:0] prime_reg = 2'b00;
    logic       rst_s;

    assign rst_s = sync_reg[1];

    // -------------------------------------------------------------------------
    // Request latch and hold countdown.
    // -------------------------------------------------------------------------
    logic          pend_reg   = 1'b0;
    logic [HW-1:0] hold_reg   = HOLD_INIT;
    logic          resetn_reg = 1'b0;

    always_ff @(posedge CLK) begin
        sync_reg  <= {sync_reg[0], RESET};
        prime_reg <= {prime_reg[0], 1'b1};

        // pend remembers a short RESET low that fell between two ticks. The
        // tick itself samples rst_s directly, so clearing on a tick never
        // loses a request. The synchroniser's power-up zeros are not a real
        // request and are ignored, so a power-up with RESET high releases the
        // core after exactly RESET_HOLD ticks.
        if (tick) begin
            pend_reg <= 1'b0;
        end else if (!rst_s && prime_reg[1]) begin
            pend_reg <= 1'b1;
        end

        if (tick) begin
            if (pend_reg || !rst_s) begin
                // Any request, including one arriving while hold==1, restarts
                // the countdown and keeps the core in reset.
                hold_reg   <= HOLD_INIT;
                resetn_reg <= 1'b0;
            end else if (hold_reg > HOLD_ONE) begin
                hold_reg   <= hold_reg - HOLD_ONE;
            end else if (hold_reg == HOLD_ONE) begin
                hold_reg   <= '0;
                resetn_reg <= 1'b1;
            end
        end
    end

    assign resetn = resetn_reg;

endmodule

// File: tb/tb_clockworks.sv
// -----------------------------------------------------------------------------
// tb_clockworks - directed bench for clockworks
//
// Two instances share one board clock:
//   u_slow  SLOW=2, RESET_HOLD=4  (clk period 8 CLK cycles, ticks at 8,16,...)
//   u_fast  SLOW=0, RESET_HOLD=1  (bypass, every CLK cycle is a tick)
// Edge n is the n-th rising edge of CLK; outputs are sampled 1 ns after it.
// RESET changes are applied 1 ns after an edge, so "drive after edge a" means
// the new level is first sampled at edge a+1.
// -----------------------------------------------------------------------------
module tb_clockworks;

    logic CLK;
    logic reset_slow;
    logic reset_fast;
    logic clk_slow;
    logic clk_fast;
    logic resetn_slow;
    logic resetn_fast;

    int edge_n = 0;
    int total  = 0;
    int bad    = 0;

    clockworks #(.SLOW(2), .RESET_HOLD(4)) u_slow (
        .CLK    (CLK),
        .RESET  (reset_slow),
        .clk    (clk_slow),
        .resetn (resetn_slow)
    );

    clockworks #(.SLOW(0), .RESET_HOLD(1)) u_fast (
        .CLK    (CLK),
        .RESET  (reset_fast),
        .clk    (clk_fast),
        .resetn (resetn_fast)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step_to(input int n);
        while (edge_n < n) begin
            @(posedge CLK);
            #1;
            edge_n++;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
            $display("check %-14s edge=%0d observed=%b expected=%b ok", tag, edge_n, obs, exp);
        else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
        end
    endtask

    initial begin
        reset_slow = 1'b1;
        reset_fast = 1'b1;
        #1;
        // Power-up state
        chk("slow_clk_pu",  clk_slow,    1'b0);
        chk("slow_rstn_pu", resetn_slow, 1'b0);
        chk("fast_rstn_pu", resetn_fast, 1'b0);
        chk("fast_clk_lo",  clk_fast,    1'b0);

        // Bypass instance: clk follows CLK, resetn follows rst_s one edge later
        step_to(1);
        chk("fast_clk_hi",  clk_fast,    1'b1);
        chk("fast_rstn_e1", resetn_fast, 1'b0);
        step_to(2);
        chk("fast_rstn_e2", resetn_fast, 1'b0);
        step_to(3);
        chk("fast_rstn_e3", resetn_fast, 1'b1);
        chk("slow_clk_e3",  clk_slow,    1'b0);

        // Divided clock phases
        step_to(4);
        chk("slow_clk_e4",  clk_slow,    1'b1);
        #5;
        chk("fast_clk_neg", clk_fast,    1'b0);
        step_to(7);
        chk("slow_clk_e7",  clk_slow,    1'b1);
        step_to(8);
        chk("slow_clk_e8",  clk_slow,    1'b0);

        // Bypass reset assert/release: 3 edges after RESET changes
        step_to(10);
        reset_fast = 1'b0;
        step_to(12);
        chk("slow_clk_e12", clk_slow,    1'b1);
        chk("fast_rstn_12", resetn_fast, 1'b1);
        step_to(13);
        chk("fast_rstn_13", resetn_fast, 1'b0);
        step_to(20);
        reset_fast = 1'b1;
        step_to(22);
        chk("fast_rstn_22", resetn_fast, 1'b0);
        step_to(23);
        chk("fast_rstn_23", resetn_fast, 1'b1);

        // Power-up release at the 4th tick
        step_to(31);
        chk("pu_rstn_31",   resetn_slow, 1'b0);
        step_to(32);
        chk("pu_rstn_32",   resetn_slow, 1'b1);

        // Long RESET low 50..70
        step_to(50);
        reset_slow = 1'b0;
        step_to(55);
        chk("long_rstn_55", resetn_slow, 1'b1);
        step_to(56);
        chk("long_rstn_56", resetn_slow, 1'b0);
        step_to(60);
        chk("long_clk_60",  clk_slow,    1'b1);
        step_to(64);
        chk("long_clk_64",  clk_slow,    1'b0);
        step_to(70);
        reset_slow = 1'b1;
        step_to(103);
        chk("long_rstn_103", resetn_slow, 1'b0);
        step_to(104);
        chk("long_rstn_104", resetn_slow, 1'b1);

        // Two-cycle pulse between ticks (sampled at 137,138)
        step_to(136);
        reset_slow = 1'b0;
        step_to(138);
        reset_slow = 1'b1;
        step_to(143);
        chk("pulse_rstn_143", resetn_slow, 1'b1);
        step_to(144);
        chk("pulse_rstn_144", resetn_slow, 1'b0);
        step_to(175);
        chk("pulse_rstn_175", resetn_slow, 1'b0);
        step_to(176);
        chk("pulse_rstn_176", resetn_slow, 1'b1);

        // Re-press while hold=2 restarts the countdown
        step_to(200);
        reset_slow = 1'b0;
        step_to(202);
        reset_slow = 1'b1;
        step_to(208);
        chk("rep_rstn_208", resetn_slow, 1'b0);
        step_to(224);
        reset_slow = 1'b0;
        step_to(226);
        reset_slow = 1'b1;
        step_to(256);
        chk("rep_rstn_256", resetn_slow, 1'b0);
        step_to(263);
        chk("rep_rstn_263", resetn_slow, 1'b0);
        step_to(264);
        chk("rep_rstn_264", resetn_slow, 1'b1);

        // RESET low at the very tick where hold would reach release
        step_to(280);
        reset_slow = 1'b0;
        step_to(282);
        reset_slow = 1'b1;
        step_to(288);
        chk("tie_rstn_288", resetn_slow, 1'b0);
        step_to(317);
        reset_slow = 1'b0;
        step_to(319);
        reset_slow = 1'b1;
        step_to(320);
        chk("tie_rstn_320", resetn_slow, 1'b0);
        step_to(359);
        chk("tie_rstn_359", resetn_slow, 1'b0);
        step_to(360);
        chk("tie_rstn_360", resetn_slow, 1'b1);
        chk("fast_rstn_360", resetn_fast, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
